// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter owning one shared load-enable register.
// Two requesters; the winner is loaded and acknowledged on the same edge.
module reg_share_arbiter #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req0,
   input  logic [WIDTH-1:0] D0,
   output logic             ack0,
   input  logic             req1,
   input  logic [WIDTH-1:0] D1,
   output logic             ack1,
   output logic [WIDTH-1:0] Q,
   output logic             last_src,
   output logic             busy,
   output logic [CNT_W-1:0] wr_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK0 = 2'd1,
      ACK1 = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   q_r, q_n;
   logic               ls_r, ls_n;
   logic               ack0_r, ack0_n;
   logic               ack1_r, ack1_n;
   logic               busy_r, busy_n;
   logic [CNT_W-1:0]   cnt_r, cnt_n;
   logic               grant0, grant1;
   logic [CNT_W-1:0]   cnt_inc;

   // Port 0 wins a tie only when port 1 was granted last.
   always_comb begin
      grant0 = req0 && (!req1 || ls_r);
      grant1 = req1 && !grant0;
   end

   always_comb begin
      cnt_inc = (cnt_r == '1) ? cnt_r : cnt_r + 1'b1;
   end

   always_comb begin
      state_n = state;
      q_n     = q_r;
      ls_n    = ls_r;
      cnt_n   = cnt_r;
      ack0_n  = 1'b0;
      ack1_n  = 1'b0;
      busy_n  = 1'b0;
      case (state)
         IDLE: begin
            if (grant0) begin
               q_n     = D0;
               ls_n    = 1'b0;
               cnt_n   = cnt_inc;
               ack0_n  = 1'b1;
               busy_n  = 1'b1;
               state_n = ACK0;
            end else if (grant1) begin
               q_n     = D1;
               ls_n    = 1'b1;
               cnt_n   = cnt_inc;
               ack1_n  = 1'b1;
               busy_n  = 1'b1;
               state_n = ACK1;
            end
         end
         ACK0, ACK1: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         q_r    <= '0;
         ls_r   <= 1'b1;
         cnt_r  <= '0;
         ack0_r <= 1'b0;
         ack1_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         state  <= state_n;
         q_r    <= q_n;
         ls_r   <= ls_n;
         cnt_r  <= cnt_n;
         ack0_r <= ack0_n;
         ack1_r <= ack1_n;
         busy_r <= busy_n;
      end
   end

   assign Q        = q_r;
   assign last_src = ls_r;
   assign ack0     = ack0_r;
   assign ack1     = ack1_r;
   assign busy     = busy_r;
   assign wr_count = cnt_r;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed and randomized bench for reg_share_arbiter against a
// transaction-level model of the arbitration rules.
module tb_reg_share_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req0, req1;
   logic [15:0] D0, D1;
   logic        ack0, ack1;
   logic [15:0] Q;
   logic        last_src;
   logic        busy;
   logic [7:0]  wr_count;

   int checks = 0;
   int errors = 0;

   // Reference model: value held, writes done, last winner, port being acked (-1 none)
   logic [15:0] m_q;
   int          m_cnt;
   logic        m_last;
   int          m_ack;

   always #5 CLK = ~CLK;

   reg_share_arbiter #(.WIDTH(16), .CNT_W(8)) dut (
      .CLK(CLK), .RST(RST),
      .req0(req0), .D0(D0), .ack0(ack0),
      .req1(req1), .D1(D1), .ack1(ack1),
      .Q(Q), .last_src(last_src), .busy(busy), .wr_count(wr_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int w;
      if (RST) begin
         m_q = 16'h0; m_cnt = 0; m_last = 1'b1; m_ack = -1;
      end else if (m_ack != -1) begin
         m_ack = -1;
      end else if (req0 || req1) begin
         if (req0 && req1) w = m_last ? 0 : 1;
         else              w = req1 ? 1 : 0;
         m_q    = (w == 1) ? D1 : D0;
         m_last = (w == 1);
         m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
         m_ack  = w;
      end
   endtask

   task automatic check_all();
      chk("Q",        32'(Q),        32'(m_q));
      chk("ack0",     32'(ack0),     32'(m_ack == 0));
      chk("ack1",     32'(ack1),     32'(m_ack == 1));
      chk("busy",     32'(busy),     32'(m_ack != -1));
      chk("last_src", 32'(last_src), 32'(m_last));
      chk("wr_count", 32'(wr_count), 32'(m_cnt));
      chk("ack_mutex", 32'(ack0 & ack1), 32'h0);
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      RST = 1'b1; req0 = 1'b0; req1 = 1'b0;
      tick();
      RST = 1'b0;
   endtask

   initial begin
      int grants;
      logic [15:0] last_d;
      m_q = 16'h0; m_cnt = 0; m_last = 1'b1; m_ack = -1;
      RST = 1'b1; req0 = 1'b0; req1 = 1'b0; D0 = 16'h0; D1 = 16'h0;

      // Reset then single write
      tick(); tick();
      chk("rst_Q", 32'(Q), 32'h0);
      chk("rst_ack0", 32'(ack0), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_last", 32'(last_src), 32'h1);
      chk("rst_cnt", 32'(wr_count), 32'h0);
      RST = 1'b0; req0 = 1'b1; D0 = 16'hAAAA;
      tick();
      chk("w1_Q", 32'(Q), 32'hAAAA);
      chk("w1_ack0", 32'(ack0), 32'h1);
      req0 = 1'b0;
      tick();
      chk("w1_ack0_drop", 32'(ack0), 32'h0);
      chk("w1_busy", 32'(busy), 32'h0);
      chk("w1_cnt", 32'(wr_count), 32'h1);
      chk("w1_last", 32'(last_src), 32'h0);

      // Contention from reset
      do_reset();
      req0 = 1'b1; D0 = 16'hBBBB; req1 = 1'b1; D1 = 16'hCCCC;
      tick();
      chk("c_Q0", 32'(Q), 32'hBBBB);
      chk("c_ack0", 32'(ack0), 32'h1);
      req0 = 1'b0;
      tick();
      tick();
      chk("c_Q1", 32'(Q), 32'hCCCC);
      chk("c_ack1", 32'(ack1), 32'h1);
      req1 = 1'b0;
      tick();

      // Continuous contention
      do_reset();
      req0 = 1'b1; req1 = 1'b1; D0 = 16'h1111; D1 = 16'h2222;
      grants = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack0 || ack1) begin
            grants++;
            chk("cc_Q", 32'(Q), (grants % 2 == 1) ? 32'h1111 : 32'h2222);
            chk("cc_last", 32'(last_src), (grants % 2 == 1) ? 32'h0 : 32'h1);
         end
      end
      chk("cc_grants", 32'(grants), 32'd6);
      chk("cc_cnt", 32'(wr_count), 32'd6);
      req0 = 1'b0; req1 = 1'b0;
      tick();

      // Hold behaviour
      req0 = 1'b1; D0 = 16'hEEEE;
      tick();
      req0 = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         D0 = 16'($urandom); D1 = 16'($urandom);
         tick();
         chk("hold_Q", 32'(Q), 32'hEEEE);
         chk("hold_ack", 32'({ack0, ack1}), 32'h0);
         chk("hold_busy", 32'(busy), 32'h0);
      end

      // Reset during ack1, request left high
      req1 = 1'b1; D1 = 16'h5A5A;
      tick();
      chk("ra_ack1", 32'(ack1), 32'h1);
      RST = 1'b1;
      tick();
      chk("ra_Q", 32'(Q), 32'h0);
      chk("ra_ack1_cut", 32'(ack1), 32'h0);
      chk("ra_cnt", 32'(wr_count), 32'h0);
      chk("ra_last", 32'(last_src), 32'h1);
      RST = 1'b0;
      tick();
      chk("ra_regrant", 32'(ack1), 32'h1);
      chk("ra_regrant_Q", 32'(Q), 32'h5A5A);
      req1 = 1'b0;
      tick();

      // Counter saturation
      do_reset();
      req0 = 1'b1;
      last_d = 16'h0;
      for (int i = 0; i < 260; i++) begin
         D0 = 16'($urandom);
         last_d = D0;
         tick();
         tick();
         if (i >= 254) chk("sat_cnt", 32'(wr_count), 32'd255);
      end
      chk("sat_Q", 32'(Q), 32'(last_d));
      req0 = 1'b0;
      tick();

      // Randomized handshaking traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            RST = 1'b1; req0 = 1'b0; req1 = 1'b0;
         end else begin
            RST = 1'b0;
            if (!req0) begin
               D0 = 16'($urandom);
               if ($urandom_range(0, 2) == 0) req0 = 1'b1;
            end
            if (!req1) begin
               D1 = 16'($urandom);
               if ($urandom_range(0, 2) == 0) req1 = 1'b1;
            end
         end
         tick();
         if (m_ack == 0) req0 = 1'b0;
         if (m_ack == 1) req1 = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
